rom_loader: RTL and testbench
=============================

// Module: rom_loader
// PURPOSE
//  Wishbone-classic initiator that drives the 32-bit write backdoor (cyc/strobe/we/addr/data/ack)
//  of the rom and ram blocks. It takes a byte stream (valid/ready), packs 4 bytes per word and
//  writes NUM_WORDS words from BASE_ADDR. It holds the cpu via cpu_hold until the image is loaded,
//  so system can boot from a host-supplied program instead of a fixed ROM image.
// PARAMETERS
//  BASE_ADDR  32'h0  first write address
//  NUM_WORDS  64     words per load, 1..65535
//  ADDR_STEP  4      addr_o increment per word
//  TIMEOUT    255    max cycles strobe_o waits for ack_i before abort, 1..65535
// PORTS
//  clock     in   1   system clock, all state on rising edge
//  reset     in   1   asynchronous, active-low
//  start     in   1   pulse: begin a load; ignored while busy
//  in_data   in   8   stream byte
//  in_valid  in   1   in_data valid
//  in_ready  out  1   byte accepted when in_valid && in_ready
//  cyc_o     out  1   wishbone cycle
//  strobe_o  out  1   wishbone strobe
//  we_o      out  1   write enable, tied 1 while cyc_o, else 0
//  addr_o    out  32  word address
//  data_o    out  32  packed word
//  ack_i     in   1   target acknowledge
//  busy      out  1   load in progress
//  done      out  1   1-cycle pulse: all words written
//  error     out  1   sticky: ack timeout; cleared by next accepted start
//  cpu_hold  out  1   1 = keep cpu in reset
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE; all outputs 0 except cpu_hold=0; counters/word reg cleared.
//   Bus released immediately, with no wait for ack. Reset mid-write aborts the load, and no partial word is written.
//  FSM: IDLE -> COLLECT -> WRITE -> (COLLECT | DONE | ERR) -> IDLE.
//  IDLE:    start=1 -> COLLECT. word_cnt=0, byte_cnt=0, addr_o=BASE_ADDR, error=0, busy=1,
//           cpu_hold=1 (all registered, visible the cycle after start).
//  COLLECT: in_ready=1. On accept, byte k (k=byte_cnt) goes to data_o[8k+7:8k] (little-endian).
//           On acceptance of byte 3 -> WRITE. cyc_o/strobe_o rise the next cycle.
//           in_valid low stalls indefinitely, with no timeout in COLLECT.
//  WRITE:   cyc_o=strobe_o=we_o=1. in_ready=0. addr_o/data_o stable until ack.
//           ack_i sampled high (may be in the first strobe cycle) -> cyc_o/strobe_o drop the next cycle.
//           If word_cnt==NUM_WORDS-1 -> DONE. Otherwise word_cnt++, addr_o+=ADDR_STEP (32-bit wrap), byte_cnt=0 -> COLLECT.
//           Timer counts strobe cycles without ack. At TIMEOUT cycles without ack -> ERR.
//  DONE:    done=1 for exactly one cycle. busy=0 and cpu_hold=0 in the same cycle -> IDLE.
//  ERR:     cyc_o/strobe_o=0, error=1, busy=0, cpu_hold stays 1 (cpu not released on bad image) -> IDLE.
//           The next start clears error and retries from BASE_ADDR.
//  Timing:  minimum 5 cycles per word (4 accepts + 1 strobe with immediate ack).
//           Full-load minimum is 5*NUM_WORDS+1 cycles from start to done.
//  Edge cases:
//   - start while busy: no effect.
//   - start together with in_valid in IDLE: the byte is not accepted (in_ready=0 in IDLE).
//   - ack_i outside WRITE: ignored.
//   - ack_i on the same cycle the timer reaches TIMEOUT: ack wins.
// TESTING
//  1. NUM_WORDS=2. Bytes 01,02,03,04,05,06,07,08 with zero-wait ack ->
//     writes (0x0,0x04030201), (0x4,0x08070605). done 1 cycle at 11 cycles after start. cpu_hold 1->0 with done.
//  2. ack_i delayed 3 cycles -> strobe_o/addr_o/data_o held for 4 cycles. A single write per word.
//  3. ack_i never asserted, TIMEOUT=8 -> strobe_o high exactly 8 cycles, then error=1, cpu_hold=1, busy=0.
//     Then a new start gives error=0 and addr_o=BASE_ADDR.
//  4. in_valid toggled every other cycle -> no lost or duplicated bytes. in_ready never high in WRITE.
//  5. reset low mid-WRITE -> cyc_o/strobe_o 0 asynchronously. After release: IDLE, outputs 0, and the load restarts cleanly on start.
//  6. start pulsed during COLLECT -> ignored, with byte_cnt/addr_o unchanged.

Source files
------------

// File: rtl/rom_loader_if.sv
// Byte-stream input and Wishbone-classic write port of rom_loader.
// master = the loader side, slave = the stream source / memory target side.
interface rom_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        cyc_o;
    logic        strobe_o;
    logic        we_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic        ack_i;

    modport master (
        input  in_data, in_valid, ack_i,
        output in_ready, cyc_o, strobe_o, we_o, addr_o, data_o
    );

    modport slave (
        output in_data, in_valid, ack_i,
        input  in_ready, cyc_o, strobe_o, we_o, addr_o, data_o
    );
endinterface

// File: rtl/rom_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes NUM_WORDS of them over
// a Wishbone-classic backdoor, holding the cpu in reset until the image is fully loaded.
module rom_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned NUM_WORDS = 64,
    parameter logic [31:0] ADDR_STEP = 32'd4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    rom_loader_if.master bus,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic         cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_DONE    = 3'd3,
        S_ERR     = 3'd4
    } state_t;

    localparam logic [15:0] LAST_WORD = 16'(NUM_WORDS - 1);
    localparam logic [15:0] LAST_TICK = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [15:0] word_cnt_q;
    logic [15:0] timer_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] data_d;
    logic        in_ready_q;
    logic        cyc_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic        hold_q;
    logic        accept_s;

    assign accept_s = bus.in_valid && in_ready_q;

    // Merge the incoming byte into its little-endian lane of the word being assembled.
    always_comb begin
        data_d = data_q;
        case (byte_cnt_q)
            2'd0:    data_d[7:0]   = bus.in_data;
            2'd1:    data_d[15:8]  = bus.in_data;
            2'd2:    data_d[23:16] = bus.in_data;
            2'd3:    data_d[31:24] = bus.in_data;
            default: data_d        = data_q;
        endcase
    end

    // Load sequencer; every output is a register so the bus drops the instant reset asserts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            word_cnt_q <= 16'd0;
            timer_q    <= 16'd0;
            byte_cnt_q <= 2'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            in_ready_q <= 1'b0;
            cyc_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_COLLECT;
                        word_cnt_q <= 16'd0;
                        byte_cnt_q <= 2'd0;
                        timer_q    <= 16'd0;
                        addr_q     <= BASE_ADDR;
                        error_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        hold_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (accept_s) begin
                        data_q     <= data_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q    <= S_WRITE;
                            in_ready_q <= 1'b0;
                            cyc_q      <= 1'b1;
                            timer_q    <= 16'd0;
                        end
                    end
                end
                S_WRITE: begin
                    // An ack arriving on the final timer tick still completes the write.
                    if (bus.ack_i) begin
                        cyc_q <= 1'b0;
                        if (word_cnt_q == LAST_WORD) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q    <= S_COLLECT;
                            word_cnt_q <= word_cnt_q + 16'd1;
                            addr_q     <= addr_q + ADDR_STEP;
                            byte_cnt_q <= 2'd0;
                            in_ready_q <= 1'b1;
                        end
                    end else if (timer_q == LAST_TICK) begin
                        state_q <= S_ERR;
                        cyc_q   <= 1'b0;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    // cpu_hold stays asserted: a failed image must not be executed.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    cyc_q      <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.cyc_o    = cyc_q;
    assign bus.strobe_o = cyc_q;
    assign bus.we_o     = cyc_q;
    assign bus.addr_o   = addr_q;
    assign bus.data_o   = data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cpu_hold     = hold_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: a negedge monitor checks every bus cycle against a
// byte-queue model of the expected image; the stimulus adds hand-computed literal checks.
module tb_rom_loader;
    localparam int          NW   = 2;
    localparam int          TO   = 8;
    localparam logic [31:0] BASE = 32'h0;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy, done, error, cpu_hold;

    rom_loader_if bus();

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int ack_delay = 0;
    logic stray_ack = 1'b0;
    int load_id = 0;

    logic [7:0]  acc_bytes[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int writes_done = 0;
    int stb_run = 0;
    int last_stb_run = 0;
    int seen_id = 0;

    rom_loader #(
        .BASE_ADDR(BASE),
        .NUM_WORDS(NW),
        .ADDR_STEP(32'd4),
        .TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .bus(bus),
        .busy(busy),
        .done(done),
        .error(error),
        .cpu_hold(cpu_hold)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Target: acks after ack_delay strobe cycles (never if negative); stray_ack forces ack high.
    initial begin
        int ack_wait;
        ack_wait = 0;
        bus.ack_i = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (bus.strobe_o) begin
                bus.ack_i = stray_ack || (ack_delay >= 0 && ack_wait == ack_delay);
                ack_wait++;
            end else begin
                bus.ack_i = stray_ack;
                ack_wait  = 0;
            end
        end
    end

    // Model: word n of a load is bytes 4n..4n+3 of that load, written at BASE + 4n.
    always @(negedge clock) begin
        int i;
        if (reset) begin
            if (load_id != seen_id) begin
                seen_id = load_id;
                acc_bytes.delete();
                wr_addr.delete();
                wr_data.delete();
                writes_done = 0;
                stb_run = 0;
            end
            chkb("we_eq_cyc", bus.we_o, bus.cyc_o);
            chkb("stb_eq_cyc", bus.strobe_o, bus.cyc_o);
            if (bus.cyc_o) chkb("ready_in_write", bus.in_ready, 1'b0);
            if (!busy) chkb("ready_when_not_busy", bus.in_ready, 1'b0);
            if (bus.strobe_o) begin
                i = 4 * writes_done;
                chk("bytes_before_write", 32'(acc_bytes.size()), 32'(i + 4));
                chk("write_addr", bus.addr_o, BASE + 32'(i));
                if (acc_bytes.size() >= i + 4)
                    chk("write_data", bus.data_o,
                        {acc_bytes[i+3], acc_bytes[i+2], acc_bytes[i+1], acc_bytes[i]});
                stb_run++;
                if (bus.ack_i) begin
                    wr_addr.push_back(bus.addr_o);
                    wr_data.push_back(bus.data_o);
                    writes_done++;
                    last_stb_run = stb_run;
                    stb_run = 0;
                end
            end else if (stb_run != 0) begin
                last_stb_run = stb_run;
                stb_run = 0;
            end
            if (bus.in_valid && bus.in_ready) acc_bytes.push_back(bus.in_data);
            if (done) chk("words_at_done", 32'(writes_done), 32'(NW));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic begin_start(output int mark);
        load_id++;
        start = 1'b1;
        mark = cyc_cnt;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        logic took;
        n = 0;
        took = 1'b0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!took && n < 64) begin
            took = bus.in_ready;
            step();
            n++;
        end
        chkb("byte_accepted", took, 1'b1);
    endtask

    task automatic send_seq(input logic [7:0] first, input int count, input int gap);
        for (int k = 0; k < count; k++) begin
            send_byte(first + 8'(k));
            if (gap > 0) begin
                bus.in_valid = 1'b0;
                repeat (gap) step();
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int at);
        int n;
        n = 0;
        while (!done && n < 300) begin
            step();
            n++;
        end
        chkb("done_seen", done, 1'b1);
        at = cyc_cnt;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int mark, at, n;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        #3;
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_done", done, 1'b0);
        chkb("rst_error", error, 1'b0);
        chkb("rst_hold", cpu_hold, 1'b0);
        chkb("rst_cyc", bus.cyc_o, 1'b0);
        chkb("rst_ready", bus.in_ready, 1'b0);
        chk("rst_addr", bus.addr_o, 32'h0);
        chk("rst_data", bus.data_o, 32'h0);
        #10 reset = 1'b1;
        step();

        // 1: two words, zero-wait ack
        ack_delay = 0;
        begin_start(mark);
        chkb("t1_busy", busy, 1'b1);
        chkb("t1_hold", cpu_hold, 1'b1);
        chkb("t1_ready", bus.in_ready, 1'b1);
        chk("t1_addr", bus.addr_o, BASE);
        send_seq(8'h01, 8, 0);
        wait_done(at);
        chk("t1_done_cycle", 32'(at - mark), 32'd11);
        chkb("t1_hold_released", cpu_hold, 1'b0);
        chkb("t1_busy_low", busy, 1'b0);
        chk("t1_nwrites", 32'(wr_addr.size()), 32'd2);
        chk("t1_addr0", wr_addr[0], 32'h0);
        chk("t1_data0", wr_data[0], 32'h04030201);
        chk("t1_addr1", wr_addr[1], 32'h4);
        chk("t1_data1", wr_data[1], 32'h08070605);
        step();
        chkb("t1_done_pulse", done, 1'b0);

        // 2: ack delayed 3 cycles
        ack_delay = 3;
        begin_start(mark);
        send_seq(8'h10, 8, 0);
        wait_done(at);
        chk("t2_strobe_len", 32'(last_stb_run), 32'd4);
        chk("t2_nwrites", 32'(wr_data.size()), 32'd2);
        chk("t2_data1", wr_data[1], 32'h17161514);
        step();

        // 3: no ack -> timeout, then retry
        ack_delay = -1;
        begin_start(mark);
        send_seq(8'h20, 4, 0);
        n = 0;
        while (!error && n < 100) begin
            step();
            n++;
        end
        chkb("t3_error", error, 1'b1);
        chkb("t3_hold", cpu_hold, 1'b1);
        chkb("t3_busy", busy, 1'b0);
        chkb("t3_stb_low", bus.strobe_o, 1'b0);
        step();
        chk("t3_strobe_len", 32'(last_stb_run), 32'(TO));
        chk("t3_nwrites", 32'(wr_addr.size()), 32'd0);
        ack_delay = 0;
        begin_start(mark);
        chkb("t3_error_clr", error, 1'b0);
        chk("t3_addr_base", bus.addr_o, BASE);
        send_seq(8'h30, 8, 0);
        wait_done(at);
        chk("t3_retry_data0", wr_data[0], 32'h33323130);
        step();

        // 4: in_valid toggled, stray ack outside WRITE
        stray_ack = 1'b1;
        begin_start(mark);
        send_seq(8'hA0, 8, 1);
        wait_done(at);
        chk("t4_nwrites", 32'(wr_data.size()), 32'd2);
        chk("t4_data0", wr_data[0], 32'hA3A2A1A0);
        chk("t4_data1", wr_data[1], 32'hA7A6A5A4);
        stray_ack = 1'b0;
        step();

        // 5: reset asserted mid-WRITE
        ack_delay = -1;
        begin_start(mark);
        send_seq(8'h40, 4, 0);
        step();
        chkb("t5_in_write", bus.strobe_o, 1'b1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chkb("t5_cyc_async", bus.cyc_o, 1'b0);
        chkb("t5_stb_async", bus.strobe_o, 1'b0);
        chkb("t5_busy", busy, 1'b0);
        chkb("t5_hold", cpu_hold, 1'b0);
        chk("t5_addr", bus.addr_o, 32'h0);
        chk("t5_data", bus.data_o, 32'h0);
        step();
        reset = 1'b1;
        step();
        chkb("t5_idle_busy", busy, 1'b0);
        chkb("t5_idle_ready", bus.in_ready, 1'b0);
        chk("t5_no_partial", 32'(wr_addr.size()), 32'd0);
        ack_delay = 0;
        begin_start(mark);
        send_seq(8'h50, 8, 0);
        wait_done(at);
        chk("t5_restart_addr0", wr_addr[0], 32'h0);
        chk("t5_restart_data0", wr_data[0], 32'h53525150);
        step();

        // 6: start with in_valid in IDLE, then start pulsed during COLLECT
        bus.in_data  = 8'hEE;
        bus.in_valid = 1'b1;
        begin_start(mark);
        send_seq(8'h60, 2, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t6_addr_kept", bus.addr_o, BASE);
        chkb("t6_busy", busy, 1'b1);
        chkb("t6_ready", bus.in_ready, 1'b1);
        send_seq(8'h62, 6, 0);
        wait_done(at);
        chk("t6_nwrites", 32'(wr_data.size()), 32'd2);
        chk("t6_data0", wr_data[0], 32'h63626160);
        chk("t6_data1", wr_data[1], 32'h67666564);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
